counter_sched: RTL

COUNTER_SCHED -- requirements
Module: counter_sched

---
 rtl/counter_sched_pkg.sv | 14 +
 rtl/counter_core.sv | 27 ++
 rtl/counter_sched.sv | 117 +++++++++++
 3 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter scheduler.
// The optional round-robin arbiter is enabled with COUNTER_SCHED_RR_EN.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ          = 2;
    localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/counter_core.sv
// WIDTH-bit up counter with synchronous active-low reset, synchronous clear
// and count enable; clear takes precedence over enable.
module counter_core
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/counter_sched.sv
// Two-requester counter scheduler: arbitrates, runs the shared counter up to
// the winner's terminal count, then pulses done. Macro: COUNTER_SCHED_RR_EN.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    input  logic             hold,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic [WIDTH-1:0] counter_out
);

    state_t           state_reg;
    state_t           state_next;
    logic             owner_reg;
    logic [WIDTH-1:0] len_q_reg;
    logic             winner;
    logic             grant;
    logic             at_end;
    logic             count_clear;
    logic             count_enable;
    logic [WIDTH-1:0] count;

    assign grant  = (state_reg == IDLE) && (req != 2'b00);
    assign at_end = (count == len_q_reg);

`ifdef COUNTER_SCHED_RR_EN
    // Pointer names the requester that wins the next tie.
    logic ptr_reg;

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_reg <= 1'b0;
        end else if (grant) begin
            ptr_reg <= ~winner;
        end
    end

    always_comb begin
        winner = 1'b0;
        if (req[0] && req[1]) begin
            winner = ptr_reg;
        end else if (req[1]) begin
            winner = 1'b1;
        end
    end
`else
    always_comb begin
        winner = 1'b0;
        if (!req[0] && req[1]) begin
            winner = 1'b1;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_reg <= 1'b0;
            len_q_reg <= '0;
        end else if (grant) begin
            owner_reg <= winner;
            len_q_reg <= winner ? len1 : len0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant) state_next = RUN;
            RUN:     if (!hold && at_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counting stops at len_q, so the counter never wraps.
    always_comb begin
        count_clear  = grant;
        count_enable = (state_reg == RUN) && !hold && !at_end;
        busy         = (state_reg == RUN) || (state_reg == DONE);
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
            assign gnt[gi]  = (state_reg == RUN)  && (owner_reg == 1'(gi));
            assign done[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
        end
    endgenerate

    counter_core #(
        .WIDTH (WIDTH)
    ) u_counter_core (
        .clock  (clock),
        .reset  (reset),
        .clear  (count_clear),
        .enable (count_enable),
        .count  (count)
    );

    assign counter_out = count;

endmodule
